// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared constants for the SHA-1 match collector
package sha1_pkg;

  localparam int DIGEST_W = 160;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sha1_hit_fifo.sv
// rtl/sha1_hit_fifo.sv - synchronous hit FIFO with flush and next-empty lookahead
module sha1_hit_fifo #(
  parameter int WIDTH = 176,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             will_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level;
  logic [AW:0]      level_nxt;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty when the index bits are equal.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign level      = wr_ptr - rd_ptr;
  assign level_nxt  = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign will_empty = flush || (level_nxt == '0);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha1_match_collector.sv
// rtl/sha1_match_collector.sv - counts guesser hashes/matches and queues hits for a consumer
module sha1_match_collector
  import sha1_pkg::*;
#(
  parameter int NONCE_SIZE = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hash_in,
  input  logic                  match_in,
  input  logic                  done_in,
  input  logic [NONCE_SIZE-1:0] nonce_in,
  input  logic [DIGEST_W-1:0]   digest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NONCE_SIZE-1:0] out_nonce,
  output logic [DIGEST_W-1:0]   out_digest,
  output logic [CNT_W-1:0]      hash_count,
  output logic [CNT_W-1:0]      match_count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  sweep_done
);

  localparam int WIDTH = NONCE_SIZE + DIGEST_W;

  logic [1:0]       state;
  logic             active;
  logic             hash_v;
  logic             match_v;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_will_empty;
  logic [WIDTH-1:0] fifo_rdata;

  // A start cycle restarts the sweep, so events arriving with it are discarded.
  assign active  = ((state == ST_RUN) || (state == ST_DRAIN)) && !start;
  assign hash_v  = hash_in && active;
  assign match_v = match_in && active;

  sha1_hit_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (start),
    .push       (match_v),
    .wdata      ({nonce_in, digest_in}),
    .pop        (out_ready),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .will_empty (fifo_will_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_nonce  = fifo_rdata[WIDTH-1:DIGEST_W];
  assign out_digest = fifo_rdata[DIGEST_W-1:0];
  assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
  assign sweep_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hash_count  <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (start) begin
      state       <= ST_RUN;
      hash_count  <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (hash_v && (hash_count != {CNT_W{1'b1}})) begin
        hash_count <= hash_count + CNT_W'(1);
      end
      if (match_v && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
      // A same-cycle pop frees the slot, so a full FIFO only drops without one.
      if (match_v && fifo_full && !(out_valid && out_ready)) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_RUN:   if (done_in) state <= ST_DRAIN;
        ST_DRAIN: if (fifo_will_empty) state <= ST_DONE;
        default:  state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_match_collector.sv
// tb/tb_sha1_match_collector.sv - scoreboard and table-driven bench for sha1_match_collector
`timescale 1ns/1ps
module tb_sha1_match_collector;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  typedef struct packed {
    logic [15:0]  nonce;
    logic [159:0] digest;
  } hit_t;

  typedef struct {
    int          n;
    logic [15:0] mask;
    bit          rd;
    int          exp_hash;
    int          exp_match;
    bit          exp_ovf;
    bit          exp_valid;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, hash_in, match_in, done_in, out_ready;
  logic [15:0]  nonce_in;
  logic [159:0] digest_in;
  logic         out_valid, overflow, busy, sweep_done;
  logic [15:0]  out_nonce;
  logic [159:0] out_digest;
  logic [31:0]  hash_count, match_count;

  logic         s_start, s_hash, s_valid, s_ovf, s_busy, s_done;
  logic [15:0]  s_nonce;
  logic [159:0] s_digest;
  logic [2:0]   s_hash_count, s_match_count;

  int   checks = 0;
  int   errors = 0;
  hit_t sb[$];
  int   m_state;
  int unsigned m_hash, m_match;
  bit   m_ovf;
  bit   last_valid;
  int   pops;
  vec_t vt[3];

  always #5 clk = ~clk;

  sha1_match_collector #(.NONCE_SIZE(16), .DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hash_in(hash_in), .match_in(match_in),
    .done_in(done_in), .nonce_in(nonce_in), .digest_in(digest_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_nonce(out_nonce), .out_digest(out_digest),
    .hash_count(hash_count), .match_count(match_count), .overflow(overflow),
    .busy(busy), .sweep_done(sweep_done)
  );

  sha1_match_collector #(.NONCE_SIZE(16), .DEPTH(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .hash_in(s_hash), .match_in(1'b0),
    .done_in(1'b0), .nonce_in(16'h0), .digest_in(160'h0), .out_valid(s_valid),
    .out_ready(1'b1), .out_nonce(s_nonce), .out_digest(s_digest),
    .hash_count(s_hash_count), .match_count(s_match_count), .overflow(s_ovf),
    .busy(s_busy), .sweep_done(s_done)
  );

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs();
    hit_t head;
    chk("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      head = sb[0];
      chk("out_nonce", out_nonce, head.nonce);
      chk("out_digest", out_digest, head.digest);
    end
    chk("hash_count", hash_count, m_hash);
    chk("match_count", match_count, m_match);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (m_state == M_RUN) || (m_state == M_DRAIN));
    chk("sweep_done", sweep_done, m_state == M_DONE);
  endtask

  // Drive one cycle of stimulus, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit st, input bit hs, input bit mt, input bit dn,
                       input bit rd, input logic [15:0] nc);
    bit act, pop, full;
    start = st; hash_in = hs; match_in = mt; done_in = dn; out_ready = rd;
    nonce_in = nc;
    digest_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check_outputs();
    last_valid = out_valid;
    act  = ((m_state == M_RUN) || (m_state == M_DRAIN)) && !st;
    pop  = (sb.size() != 0) && rd;
    full = (sb.size() == 4);
    @(posedge clk);
    if (st) begin
      sb.delete();
      m_hash = 0; m_match = 0; m_ovf = 0; m_state = M_RUN;
    end else begin
      if (pop) void'(sb.pop_front());
      if (act && hs) m_hash++;
      if (act && mt) begin
        m_match++;
        if (!full || pop) sb.push_back({nc, digest_in});
        else m_ovf = 1;
      end
      if (m_state == M_RUN && dn) m_state = M_DRAIN;
      else if (m_state == M_DRAIN && sb.size() == 0) m_state = M_DONE;
    end
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_hash = 0; m_match = 0; m_ovf = 0; m_state = M_IDLE;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 0; hash_in = 0; match_in = 0; done_in = 0; out_ready = 0;
    nonce_in = '0; digest_in = '0; s_start = 0; s_hash = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 16'h0005);
    cycle(0, 0, 0, 0, 0, 0);

    vt[0] = '{10, 16'b0000_0000_0100_0100, 1'b1, 10, 2, 1'b0, 1'b0};
    vt[1] = '{5,  16'b0000_0000_0001_0101, 1'b1, 5,  3, 1'b0, 1'b0};
    vt[2] = '{6,  16'b0000_0000_0011_1111, 1'b0, 6,  6, 1'b1, 1'b1};
    for (int r = 0; r < 3; r++) begin
      cycle(1, 1, 1, 0, vt[r].rd, 16'hffff);
      for (int i = 0; i < vt[r].n; i++) begin
        cycle(0, 1, vt[r].mask[i], 0, vt[r].rd, 16'(i));
      end
      cycle(0, 0, 0, 0, vt[r].rd, 0);
      @(negedge clk);
      chk("tbl_hash_count", hash_count, vt[r].exp_hash);
      chk("tbl_match_count", match_count, vt[r].exp_match);
      chk("tbl_overflow", overflow, vt[r].exp_ovf);
      chk("tbl_out_valid", out_valid, vt[r].exp_valid);
      @(posedge clk); #1;
    end

    cycle(0, 1, 1, 0, 1, 16'h0100);
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 0, 1, 0);
      pops += int'(last_valid);
    end
    chk("full_push_pop_level", pops, 4);
    chk("full_push_pop_match_count", match_count, 7);
    chk("full_push_pop_overflow", overflow, 1);

    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 16'h0010 + 16'(i));
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_held_busy", busy, 1);
    chk("drain_held_sweep_done", sweep_done, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("drain_done_after_last_pop", sweep_done, 1);
    chk("drain_done_busy", busy, 0);
    @(posedge clk); #1;

    cycle(1, 1, 1, 0, 0, 16'h0020);
    @(negedge clk);
    chk("start_in_done_busy", busy, 1);
    chk("start_in_done_hash", hash_count, 0);
    @(posedge clk); #1;
    cycle(0, 1, 1, 0, 0, 16'h0030);
    cycle(0, 1, 1, 0, 0, 16'h0031);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("start_in_drain_valid", out_valid, 0);
    chk("start_in_drain_match", match_count, 0);
    chk("start_in_drain_busy", busy, 1);
    @(posedge clk); #1;

    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("empty_drain_two_cycles", sweep_done, 1);
    @(posedge clk); #1;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 16'h0040);
    cycle(0, 1, 1, 0, 0, 16'h0041);
    #3 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_counts", {hash_count, match_count}, 0);
    chk("reset_flags", {overflow, busy, sweep_done}, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(0, 1, 0, 0, 1, 0);

    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_hash  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      chk("sat_hash_count", s_hash_count, (i < 7) ? i : 7);
    end
    s_hash = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
